cdc_data_qualifier: RTL and testbench
=====================================

Name: cdc_data_qualifier

Overview:
Consumer stage in the b_clk domain, placed directly after the two-flop bus synchronizer. It takes the synchronized multi-bit bus (sync_data) and filters it for stability: a value is committed only after it has been held for STABLE_CYCLES+1 consecutive samples. This rejects the incoherent intermediate codes a multi-bit bus can show while crossing. Each committed change is queued as an event in a small FIFO with a valid/ready output handshake.

Parameters:
WIDTH, 4, bit width of the synchronized bus and of event data
STABLE_CYCLES, 2, extra consecutive equal samples required before commit; must be >= 1
FIFO_DEPTH, 4, event queue depth; power of 2, >= 2

Ports:
b_clk  input  1  sole clock
b_rst_n  input  1  reset, synchronous, active-high (asserted = 1)
sync_data  input  WIDTH  synchronized bus from the upstream synchronizer
out_data  output  WIDTH  head event value; 0 when queue is empty
out_valid  output  1  queue non-empty
out_ready  input  1  consumer accepts head event when out_valid=1
stable_data  output  WIDTH  last committed (qualified) value
level  output  clog2(FIFO_DEPTH+1)  number of queued events
overflow  output  1  sticky flag: a commit event was dropped because the queue was full

Behaviour:
- Reset (b_rst_n=1 at a b_clk edge) clears everything: cand=0, cnt=0, stable_data=0, queue empty, level=0, out_valid=0, out_data=0, overflow=0. Reset has priority over all other activity.
- Reset mid-operation discards queued events and any pending candidate. No event is generated from pre-reset state.
- Candidate tracking, each edge:
  - if sync_data != cand: cand<=sync_data, cnt<=0
  - else if cnt < STABLE_CYCLES: cnt<=cnt+1
  - else cnt holds; it saturates at STABLE_CYCLES
- Commit condition, evaluated on registered state: (cnt == STABLE_CYCLES) and (cand != stable_data).
  - On commit: stable_data<=cand, and a push of cand to the queue is requested in the same edge.
  - Commit happens even if sync_data changes on that edge.
  - Holding the same value generates exactly one event.
  - Returning to the current stable_data after a glitch generates no event.
- Latency: a value first sampled at edge t and held through edge t+STABLE_CYCLES appears on stable_data after edge t+STABLE_CYCLES+1. It appears on out_valid/out_data in that same cycle if the queue was empty.
- Any change before the (STABLE_CYCLES+1)th sample restarts qualification, so no event is produced for the glitched value.
- Queue behaviour:
  - First-word-fall-through; out_data is the head entry.
  - Pop on out_valid & out_ready.
  - Push and pop in the same edge: both occur and level is unchanged. This includes the full case, where the push is accepted and overflow is not set.
  - Push with the queue full and no pop: the event is dropped and overflow<=1. stable_data still updates.
  - overflow clears only on reset.
  - out_ready while empty has no effect.
  - Pointers wrap modulo FIFO_DEPTH.
- level = pushes minus pops, range 0..FIFO_DEPTH. out_valid = (level != 0).

Test Plan:
1. Reset, then sync_data=0 held for 20 cycles -> out_valid=0, stable_data=0, level=0, overflow=0.
2. STABLE_CYCLES=2, out_ready=1, sync_data steps to 4'hA (first sampled edge 0) and is held -> after edge 3: stable_data=4'hA, out_valid=1, out_data=4'hA for exactly one cycle; then level=0.
3. From stable 4'hA: sync_data=4'h5 for 2 edges, then back to 4'hA -> no out_valid, stable_data stays 4'hA. Then 4'h5 held 3 edges -> one event 4'h5.
4. out_ready=0, five successive stable values 1,2,3,4,5 each held 4 cycles -> level=4, overflow=1, stable_data=5. Then out_ready=1 drains 1,2,3,4 in order; 5 is never output.
5. Queue full (level=4), out_ready=1 on the same edge as a new commit of 4'h7 -> level stays 4, overflow stays 0, 4'h7 is last out after the drain.
6. Two entries queued and cnt=1 on a new candidate, b_rst_n=1 for one edge -> next cycle out_valid=0, level=0, out_data=0, stable_data=0, overflow=0. No event for the interrupted candidate unless it is re-qualified from scratch.

Source files
------------

// File: rtl/cdc_data_qualifier.sv
// Stability filter for a synchronized multi-bit bus. A value is committed
// once it has been sampled STABLE_CYCLES+1 times in a row, and each commit is queued as an event.
module cdc_data_qualifier #(
    parameter int WIDTH         = 4,
    parameter int STABLE_CYCLES = 2,
    parameter int FIFO_DEPTH    = 4,
    localparam int LW = $clog2(FIFO_DEPTH + 1),
    localparam int CW = $clog2(STABLE_CYCLES + 1),
    localparam int PW = $clog2(FIFO_DEPTH)
) (
    input  logic             b_clk,
    input  logic             b_rst_n,
    input  logic [WIDTH-1:0] sync_data,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] stable_data,
    output logic [LW-1:0]    level,
    output logic             overflow
);

    logic [WIDTH-1:0] cand;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    logic commit;
    logic full;
    logic pop;
    logic push_ok;

    // Commit uses registered state only, so a change on sync_data in the
    // same edge cannot cancel a value that has already qualified.
    assign commit  = (cnt == CW'(STABLE_CYCLES)) && (cand != stable_data);
    assign full    = (level == LW'(FIFO_DEPTH));
    assign out_valid = (level != '0);
    assign pop     = out_valid && out_ready;
    assign push_ok = commit && (!full || pop);
    assign out_data = out_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge b_clk) begin
        if (b_rst_n) begin
            cand <= '0;
            cnt  <= '0;
        end else if (sync_data != cand) begin
            cand <= sync_data;
            cnt  <= '0;
        end else if (cnt < CW'(STABLE_CYCLES)) begin
            cnt <= cnt + CW'(1);
        end
    end

    always_ff @(posedge b_clk) begin
        if (b_rst_n) begin
            stable_data <= '0;
            overflow    <= 1'b0;
        end else if (commit) begin
            stable_data <= cand;
            if (!push_ok)
                overflow <= 1'b1;
        end
    end

    always_ff @(posedge b_clk) begin
        if (b_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({push_ok, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge b_clk) begin
        if (!b_rst_n && push_ok)
            mem[wr_ptr] <= cand;
    end

endmodule

// File: tb/tb_cdc_data_qualifier.sv
// Scoreboard bench for cdc_data_qualifier: expected events are queued as
// stimulus is driven and matched against every handshake the DUT completes.
module tb_cdc_data_qualifier;

    logic       b_clk;
    logic       b_rst_n;
    logic [3:0] sync_data;
    logic [3:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] stable_data;
    logic [2:0] level;
    logic       overflow;

    int n_checks = 0;
    int n_errors = 0;
    logic [3:0] exp_q [$];

    cdc_data_qualifier #(.WIDTH(4), .STABLE_CYCLES(2), .FIFO_DEPTH(4)) dut (
        .b_clk       (b_clk),
        .b_rst_n     (b_rst_n),
        .sync_data   (sync_data),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .stable_data (stable_data),
        .level       (level),
        .overflow    (overflow)
    );

    initial b_clk = 1'b0;
    always #5 b_clk = ~b_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: note whether a handshake completes on this edge, then
    // compare the popped value with the scoreboard head.
    task automatic cyc();
        logic       p;
        logic [3:0] h;
        logic [3:0] e;
        p = out_valid && out_ready && !b_rst_n;
        h = out_data;
        @(posedge b_clk);
        #1;
        if (p) begin
            check_eq("evt_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_eq("evt_data", 32'(h), 32'(e));
            end
        end
    endtask

    task automatic hold(input logic [3:0] v, input int n);
        sync_data = v;
        repeat (n) cyc();
    endtask

    task automatic do_reset();
        b_rst_n = 1'b1;
        cyc();
        b_rst_n = 1'b0;
        exp_q.delete();
    endtask

    task automatic check_idle(input string tag, input logic [3:0] stab, input logic ovf);
        check_eq({tag, "_valid"},  32'(out_valid),   32'd0);
        check_eq({tag, "_level"},  32'(level),       32'd0);
        check_eq({tag, "_data"},   32'(out_data),    32'd0);
        check_eq({tag, "_stable"}, 32'(stable_data), 32'(stab));
        check_eq({tag, "_ovf"},    32'(overflow),    32'(ovf));
    endtask

    initial begin
        b_rst_n   = 1'b1;
        sync_data = 4'h3;
        out_ready = 1'b0;
        cyc();
        cyc();
        b_rst_n = 1'b0;
        check_idle("rst", 4'h0, 1'b0);

        // Idle bus stays quiet
        hold(4'h0, 20);
        check_idle("idle", 4'h0, 1'b0);

        // Single qualified step, latency STABLE_CYCLES+1
        out_ready = 1'b1;
        exp_q.push_back(4'hA);
        hold(4'hA, 3);
        check_eq("lat_stable_pre", 32'(stable_data), 32'h0);
        check_eq("lat_valid_pre",  32'(out_valid),   32'd0);
        cyc();
        check_eq("lat_stable", 32'(stable_data), 32'hA);
        check_eq("lat_valid",  32'(out_valid),   32'd1);
        check_eq("lat_data",   32'(out_data),    32'hA);
        check_eq("lat_level",  32'(level),       32'd1);
        cyc();
        check_idle("lat_after", 4'hA, 1'b0);

        // Glitch back to the stable value is filtered
        hold(4'h5, 2);
        hold(4'hA, 6);
        check_idle("glitch", 4'hA, 1'b0);
        exp_q.push_back(4'h5);
        hold(4'h5, 3);
        check_eq("req_stable_pre", 32'(stable_data), 32'hA);
        cyc();
        check_eq("req_stable", 32'(stable_data), 32'h5);
        check_eq("req_data",   32'(out_data),    32'h5);
        hold(4'h5, 4);
        check_idle("req_after", 4'h5, 1'b0);

        // Fill to full, fifth event dropped
        out_ready = 1'b0;
        for (int v = 1; v <= 4; v++) begin
            exp_q.push_back(4'(v));
            hold(4'(v), 4);
        end
        check_eq("fill_level", 32'(level),    32'd4);
        check_eq("fill_ovf",   32'(overflow), 32'd0);
        hold(4'h5, 4);
        check_eq("drop_level",  32'(level),       32'd4);
        check_eq("drop_ovf",    32'(overflow),    32'd1);
        check_eq("drop_stable", 32'(stable_data), 32'h5);
        check_eq("drop_head",   32'(out_data),    32'h1);
        out_ready = 1'b1;
        hold(4'h5, 6);
        check_idle("drain", 4'h5, 1'b1);
        check_eq("drain_sb", 32'(exp_q.size()), 32'd0);

        // Full queue with simultaneous pop and push
        do_reset();
        check_idle("rst2", 4'h0, 1'b0);
        out_ready = 1'b0;
        for (int v = 1; v <= 4; v++) begin
            exp_q.push_back(4'(v));
            hold(4'(v), 4);
        end
        exp_q.push_back(4'h7);
        hold(4'h7, 3);
        check_eq("pp_level_pre", 32'(level), 32'd4);
        out_ready = 1'b1;
        cyc();
        check_eq("pp_level",  32'(level),       32'd4);
        check_eq("pp_ovf",    32'(overflow),    32'd0);
        check_eq("pp_stable", 32'(stable_data), 32'h7);
        hold(4'h7, 6);
        check_idle("pp_drain", 4'h7, 1'b0);
        check_eq("pp_sb", 32'(exp_q.size()), 32'd0);

        // Reset mid-operation discards queue and pending candidate
        do_reset();
        out_ready = 1'b0;
        for (int v = 1; v <= 2; v++) begin
            exp_q.push_back(4'(v));
            hold(4'(v), 4);
        end
        check_eq("mid_level_pre", 32'(level), 32'd2);
        hold(4'h9, 2);
        do_reset();
        check_idle("mid_rst", 4'h0, 1'b0);
        hold(4'h9, 3);
        check_idle("mid_noevt", 4'h0, 1'b0);
        exp_q.push_back(4'h9);
        cyc();
        check_eq("mid_requal", 32'(stable_data), 32'h9);
        check_eq("mid_valid",  32'(out_valid),   32'd1);
        out_ready = 1'b1;
        hold(4'h9, 3);
        check_idle("mid_after", 4'h9, 1'b0);

        check_eq("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
